// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue: multi-lane in-order commit buffer with trap detection, counters and watchdog
module difftest_commit_queue #(
  parameter int NCOMMIT = 2,
  parameter int DEPTH = 8,
  parameter int XLEN = 64,
  parameter int TIMEOUT = 4096,
  parameter logic [6:0] TRAP_OPCODE = 7'h6b
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCOMMIT-1:0]      in_valid,
  input  logic [NCOMMIT*XLEN-1:0] in_pc,
  input  logic [NCOMMIT*32-1:0]   in_inst,
  input  logic [NCOMMIT-1:0]      in_wen,
  input  logic [NCOMMIT*5-1:0]    in_wdest,
  input  logic [NCOMMIT*XLEN-1:0] in_wdata,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         a0,
  output logic [NCOMMIT-1:0]      out_valid,
  output logic [NCOMMIT*XLEN-1:0] out_pc,
  output logic [NCOMMIT*32-1:0]   out_inst,
  output logic [NCOMMIT-1:0]      out_wen,
  output logic [NCOMMIT*8-1:0]    out_wdest,
  output logic [NCOMMIT*XLEN-1:0] out_wdata,
  output logic                    trap_valid,
  output logic [7:0]              trap_code,
  output logic [XLEN-1:0]         trap_pc,
  output logic [63:0]             cycle_cnt,
  output logic [63:0]             instr_cnt,
  output logic                    timeout_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(NCOMMIT + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic q_wen [DEPTH];
  logic [4:0] q_wdest [DEPTH];
  logic [XLEN-1:0] q_wdata [DEPTH];
  logic [PW-1:0] head, tail, trap_idx;
  logic [PW-1:0] wr_idx [NCOMMIT];
  logic [PW-1:0] rd_idx [NCOMMIT];
  logic [CW-1:0] count;
  logic [LW-1:0] pushed, popped, emitted;
  logic [IW-1:0] idle;
  logic fire, trap_hit;
  logic unused_a0;
  assign unused_a0 = ^a0[XLEN-1:8];
  assign in_ready = !trap_valid && (CW'(DEPTH) - count >= CW'(NCOMMIT));
  assign fire = in_ready && |in_valid;
  // Valid lanes are compacted onto consecutive slots; popped lanes behind a trap are dropped.
  always_comb begin
    pushed = '0;
    popped = trap_valid ? '0 : (count < CW'(NCOMMIT) ? LW'(count) : LW'(NCOMMIT));
    emitted = '0;
    trap_hit = 1'b0;
    trap_idx = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      wr_idx[i] = tail + PW'(pushed);
      pushed = (fire && in_valid[i]) ? pushed + LW'(1) : pushed;
      rd_idx[i] = head + PW'(i);
      if (LW'(i) < popped && !trap_hit) begin
        emitted = emitted + LW'(1);
        trap_hit = q_inst[rd_idx[i]][6:0] == TRAP_OPCODE;
        trap_idx = rd_idx[i];
      end
    end
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCOMMIT; i++)
      if (fire && in_valid[i]) begin
        q_pc[wr_idx[i]] <= in_pc[i*XLEN +: XLEN];
        q_inst[wr_idx[i]] <= in_inst[i*32 +: 32];
        q_wen[wr_idx[i]] <= in_wen[i];
        q_wdest[wr_idx[i]] <= in_wdest[i*5 +: 5];
        q_wdata[wr_idx[i]] <= in_wdata[i*XLEN +: XLEN];
      end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      out_valid <= '0;
      out_pc <= '0;
      out_inst <= '0;
      out_wen <= '0;
      out_wdest <= '0;
      out_wdata <= '0;
      trap_valid <= 1'b0;
      trap_code <= '0;
      trap_pc <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      idle <= '0;
      timeout_err <= 1'b0;
    end else begin
      head <= head + PW'(popped);
      tail <= tail + PW'(pushed);
      count <= count + CW'(pushed) - CW'(popped);
      for (int j = 0; j < NCOMMIT; j++) begin
        out_valid[j] <= LW'(j) < emitted;
        if (LW'(j) < emitted) begin
          out_pc[j*XLEN +: XLEN] <= q_pc[rd_idx[j]];
          out_inst[j*32 +: 32] <= q_inst[rd_idx[j]];
          out_wen[j] <= q_wen[rd_idx[j]] && |q_wdest[rd_idx[j]];
          out_wdest[j*8 +: 8] <= {3'b0, q_wdest[rd_idx[j]]};
          out_wdata[j*XLEN +: XLEN] <= q_wdata[rd_idx[j]];
        end
      end
      if (trap_hit) begin
        trap_valid <= 1'b1;
        trap_code <= a0[7:0];
        trap_pc <= q_pc[trap_idx];
      end
      if (!trap_valid) begin
        cycle_cnt <= cycle_cnt + 64'd1;
        instr_cnt <= instr_cnt + 64'(emitted);
        idle <= (emitted != '0) ? '0 : (idle == IW'(TIMEOUT) ? idle : idle + IW'(1));
        if (emitted == '0 && idle == IW'(TIMEOUT - 1)) timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_difftest_commit_queue.sv
// tb_difftest_commit_queue: directed scoreboard bench for the commit queue
module tb_difftest_commit_queue;
  localparam int N = 2;
  localparam int X = 64;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] in_valid = '0;
  logic [N*X-1:0] in_pc = '0;
  logic [N*32-1:0] in_inst = '0;
  logic [N-1:0] in_wen = '0;
  logic [N*5-1:0] in_wdest = '0;
  logic [N*X-1:0] in_wdata = '0;
  logic in_ready;
  logic [X-1:0] a0 = '0;
  logic [N-1:0] out_valid;
  logic [N*X-1:0] out_pc;
  logic [N*32-1:0] out_inst;
  logic [N-1:0] out_wen;
  logic [N*8-1:0] out_wdest;
  logic [N*X-1:0] out_wdata;
  logic trap_valid;
  logic [7:0] trap_code;
  logic [X-1:0] trap_pc;
  logic [63:0] cycle_cnt, instr_cnt;
  logic timeout_err;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic wen;
    logic [7:0] wdest;
    logic [63:0] wdata;
  } rec_t;
  rec_t sb[$];
  int checks = 0;
  int errors = 0;
  longint exp_instr = 0;
  always #5 clock = ~clock;
  difftest_commit_queue #(.NCOMMIT(N), .DEPTH(8), .XLEN(X), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata), .in_ready(in_ready), .a0(a0),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_wen(out_wen),
    .out_wdest(out_wdest), .out_wdata(out_wdata), .trap_valid(trap_valid), .trap_code(trap_code),
    .trap_pc(trap_pc), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .timeout_err(timeout_err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic lane(input int i, input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                      input logic [4:0] wd, input logic [63:0] data, input bit expect_out);
    in_valid[i] = 1'b1;
    in_pc[i*X +: X] = pc;
    in_inst[i*32 +: 32] = inst;
    in_wen[i] = wen;
    in_wdest[i*5 +: 5] = wd;
    in_wdata[i*X +: X] = data;
    if (expect_out) begin
      sb.push_back('{pc, inst, wen && wd != 5'd0, {3'b0, wd}, data});
      exp_instr++;
    end
  endtask
  task automatic idle_in();
    in_valid = '0;
  endtask
  // Every emitted lane must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset) begin
      chk("valid_gap", {63'b0, out_valid == 2'b10}, 64'd0);
      for (int j = 0; j < N; j++)
        if (out_valid[j]) begin
          if (sb.size() == 0) chk("unexpected_emit", {63'b0, out_valid[j]}, 64'd0);
          else begin
            rec_t e;
            e = sb.pop_front();
            chk("out_pc", out_pc[j*X +: X], e.pc);
            chk("out_inst", {32'b0, out_inst[j*32 +: 32]}, {32'b0, e.inst});
            chk("out_wen", {63'b0, out_wen[j]}, {63'b0, e.wen});
            chk("out_wdest", {56'b0, out_wdest[j*8 +: 8]}, {56'b0, e.wdest});
            chk("out_wdata", out_wdata[j*X +: X], e.wdata);
          end
        end
    end
  end
  initial begin
    repeat (3) step();
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {62'b0, out_valid}, 64'd0);
    chk("rst_cycle_cnt", cycle_cnt, 64'd0);
    chk("rst_trap_valid", {63'b0, trap_valid}, 64'd0);
    reset = 1'b0;
    repeat (3) step();
    chk("idle_cycle_cnt", cycle_cnt, 64'd3);
    chk("idle_instr_cnt", instr_cnt, 64'd0);
    chk("idle_in_ready", {63'b0, in_ready}, 64'd1);
    lane(1, 64'h80000004, 32'h00500293, 1'b1, 5'd5, 64'h55, 1'b1);
    step();
    idle_in();
    chk("latency_not_yet", {62'b0, out_valid}, 64'd0);
    step();
    chk("lane1_only_valid", {62'b0, out_valid}, 64'd1);
    chk("lane1_only_pc", out_pc[X-1:0], 64'h80000004);
    chk("lane1_only_instr", instr_cnt, 64'd1);
    lane(0, 64'h80000008, 32'h00000013, 1'b1, 5'd0, 64'hdead, 1'b1);
    lane(1, 64'h8000000c, 32'h00700393, 1'b1, 5'd7, 64'hbeef, 1'b1);
    step();
    idle_in();
    step();
    chk("wdest0_wen", {62'b0, out_wen}, 64'd2);
    chk("pair_instr", instr_cnt, 64'd3);
    for (int c = 0; c < 20; c++) begin
      logic [1:0] v;
      v = (c < 6) ? 2'b11 : 2'($urandom_range(1, 3));
      chk("burst_in_ready", {63'b0, in_ready}, 64'd1);
      for (int i = 0; i < N; i++)
        if (v[i]) lane(i, 64'h80100000 + 64'(c * 8 + i * 4), {$urandom_range(0, 32'h1ffffff), 7'h13},
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'b1);
      step();
      idle_in();
    end
    for (int b = 0; b < 10 && sb.size() != 0; b++) step();
    step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("burst_instr", instr_cnt, 64'(exp_instr));
    chk("no_timeout_yet", {63'b0, timeout_err}, 64'd0);
    lane(0, 64'h80200000, 32'h00000013, 1'b0, 5'd1, 64'h1, 1'b0);
    lane(1, 64'h80200004, 32'h00000013, 1'b0, 5'd2, 64'h2, 1'b0);
    step();
    idle_in();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    chk("flush_out_valid", {62'b0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    chk("flush_instr", instr_cnt, 64'd0);
    repeat (15) step();
    chk("flush_no_emit", instr_cnt, 64'd0);
    chk("timeout_before", {63'b0, timeout_err}, 64'd0);
    step();
    chk("timeout_set", {63'b0, timeout_err}, 64'd1);
    chk("timeout_cycles", cycle_cnt, 64'd16);
    repeat (4) step();
    chk("timeout_sticky", {63'b0, timeout_err}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_instr = 0;
    a0 = 64'h2A;
    lane(0, 64'h80001000, 32'h0000006b, 1'b0, 5'd0, 64'h0, 1'b1);
    lane(1, 64'h80001004, 32'h00000013, 1'b1, 5'd3, 64'h3, 1'b0);
    step();
    idle_in();
    step();
    chk("trap_out_valid", {62'b0, out_valid}, 64'd1);
    chk("trap_valid", {63'b0, trap_valid}, 64'd1);
    chk("trap_code", {56'b0, trap_code}, 64'h2A);
    chk("trap_pc", trap_pc, 64'h80001000);
    chk("trap_in_ready", {63'b0, in_ready}, 64'd0);
    chk("trap_instr", instr_cnt, 64'd1);
    chk("trap_cycle", cycle_cnt, 64'd2);
    chk("trap_timeout_clear", {63'b0, timeout_err}, 64'd0);
    lane(0, 64'h80002000, 32'h00000013, 1'b1, 5'd4, 64'h4, 1'b0);
    lane(1, 64'h80002004, 32'h00000013, 1'b1, 5'd5, 64'h5, 1'b0);
    step();
    idle_in();
    repeat (4) step();
    chk("frozen_cycle", cycle_cnt, 64'd2);
    chk("frozen_instr", instr_cnt, 64'd1);
    chk("frozen_out_valid", {62'b0, out_valid}, 64'd0);
    chk("trap_sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
